// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Holds the sequencer state encoding and the grouped pipeline control word.
// It also holds the reset/freeze/default control constants and the default watchdog limit.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_e;

    // Grouped pipeline enables/flushes driven by the sequencer
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
    } hz_ctrl_t;

    // Control field loaded into ID/EX when id_ex_flush is asserted
    localparam int IDEX_CTRL_W = 12;
    localparam logic [IDEX_CTRL_W-1:0] IDEX_BUBBLE = '0;

    localparam int MEM_TIMEOUT_DEFAULT = 64;

    localparam hz_ctrl_t CTRL_DEFAULT = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_flush: 1'b0,
        ex_mem_write: 1'b1, mem_wb_flush: 1'b0
    };

    localparam hz_ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, id_ex_flush: 1'b0,
        ex_mem_write: 1'b0, mem_wb_flush: 1'b1
    };

    localparam hz_ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
        id_ex_write: 1'b0, id_ex_flush: 1'b1,
        ex_mem_write: 1'b0, mem_wb_flush: 1'b1
    };

endpackage

// File: rtl/hazard_stall_ctrl_wait_timer.sv
// hazard_wait_timer: loadable saturating up-counter with a terminal flag.
// Used as the data-memory watchdog. Load has priority over increment.
// When neither load nor increment is requested, the counter returns to zero.
module hazard_wait_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MAX_COUNT = MEM_TIMEOUT_DEFAULT,
    localparam int W = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic arst,
    input  logic i_load,
    input  logic i_inc,
    output logic o_terminal
);

    logic [W-1:0] r_count;

    assign o_terminal = (r_count == W'(MAX_COUNT));

    // Count waiting cycles, holding at the limit instead of wrapping
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= W'(1);
        end else if (i_inc) begin
            if (!o_terminal) begin
                r_count <= r_count + 1'b1;
            end
        end else begin
            r_count <= '0;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: hazard and stall sequencer for the 5-stage core.
// It produces load-use bubbles, branch/jump squashes and a full freeze while data memory is busy.
// A watchdog aborts a memory access that never completes.
// Optional performance counters are enabled with the macro HAZARD_PERF_CNT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RUN         | normal flow; all hazard checks evaluated
// LOAD_STALL  | one cycle after a load-use bubble; load-use not rechecked
// MEM_WAIT    | pipeline frozen until mem_ready or watchdog expiry
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  id_jump,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write,
    output logic                  mem_wb_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]      perf_lu_stalls,
    output logic [CNT_W-1:0]      perf_mem_stalls,
    output logic [CNT_W-1:0]      perf_flushes,
`endif
    output logic                  mem_timeout_err
);

    if (MEM_TIMEOUT < 2) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_e   r_state;
    state_e   w_state_nxt;
    logic     r_timeout_err;

    logic     w_lu;
    logic     w_mem_busy;
    logic     w_timer_term;
    logic     w_released;
    logic     w_cnt_load;
    logic     w_cnt_inc;
    logic     w_err_set;

    hz_ctrl_t w_run_ctrl;
    state_e   w_run_nxt;
    logic     w_run_lu;
    logic     w_run_br;
    hz_ctrl_t w_ctrl;

    assign w_lu = ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    assign w_mem_busy = mem_req && !mem_ready;
    assign w_released = (r_state == ST_MEM_WAIT) && (mem_ready || w_timer_term);

    hazard_wait_timer #(
        .MAX_COUNT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk        (clk),
        .arst       (arst),
        .i_load     (w_cnt_load),
        .i_inc      (w_cnt_inc),
        .o_terminal (w_timer_term)
    );

    // Branch / load-use / jump resolution below the memory freeze, shared by RUN and release cycles
    always_comb begin
        w_run_ctrl = CTRL_DEFAULT;
        w_run_nxt  = ST_RUN;
        w_run_lu   = 1'b0;
        w_run_br   = 1'b0;
        if (ex_branch_taken) begin
            w_run_ctrl.if_id_flush = 1'b1;
            w_run_ctrl.id_ex_flush = 1'b1;
            w_run_br               = 1'b1;
        end else if (w_lu) begin
            w_run_ctrl.pc_write    = 1'b0;
            w_run_ctrl.if_id_write = 1'b0;
            w_run_ctrl.id_ex_flush = 1'b1;
            w_run_nxt              = ST_LOAD_STALL;
            w_run_lu               = 1'b1;
        end else if (id_jump) begin
            w_run_ctrl.if_id_flush = 1'b1;
        end
    end

    // Next state, watchdog control and pipeline outputs; reset forces the bubble-everything word
    always_comb begin
        w_ctrl      = CTRL_DEFAULT;
        w_state_nxt = ST_RUN;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_mem_busy) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = ST_MEM_WAIT;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_ctrl      = w_run_ctrl;
                    w_state_nxt = w_run_nxt;
                end
            end
            ST_LOAD_STALL: begin
                if (w_mem_busy) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = ST_MEM_WAIT;
                    w_cnt_load  = 1'b1;
                end else if (ex_branch_taken) begin
                    w_ctrl.if_id_flush = 1'b1;
                    w_ctrl.id_ex_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!w_released) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = ST_MEM_WAIT;
                    w_cnt_inc   = 1'b1;
                end else if (mem_ready) begin
                    w_ctrl      = w_run_ctrl;
                    w_state_nxt = w_run_nxt;
                end else begin
                    // watchdog expiry: release the pipe but drop the hung access
                    w_ctrl              = w_run_ctrl;
                    w_ctrl.mem_wb_flush = 1'b1;
                    w_state_nxt         = ST_RUN;
                    w_err_set           = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (arst) begin
            w_ctrl = CTRL_RESET;
        end
    end

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sticky watchdog error, cleared only by reset
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_timeout_err <= 1'b0;
        end else if (w_err_set) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign pc_write        = w_ctrl.pc_write;
    assign if_id_write     = w_ctrl.if_id_write;
    assign if_id_flush     = w_ctrl.if_id_flush;
    assign id_ex_write     = w_ctrl.id_ex_write;
    assign id_ex_flush     = w_ctrl.id_ex_flush;
    assign ex_mem_write    = w_ctrl.ex_mem_write;
    assign mem_wb_flush    = w_ctrl.mem_wb_flush;
    assign mem_timeout_err = r_timeout_err;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] PERF_MAX = '1;

    logic             w_fire_lu;
    logic             w_fire_br;
    logic             w_mem_stall;
    logic [CNT_W-1:0] r_perf_lu;
    logic [CNT_W-1:0] r_perf_mem;
    logic [CNT_W-1:0] r_perf_fl;

    assign w_fire_lu   = w_run_lu &&
                         (((r_state == ST_RUN) && !w_mem_busy) || w_released);
    assign w_fire_br   = w_run_br &&
                         (((r_state != ST_MEM_WAIT) && !w_mem_busy) || w_released);
    assign w_mem_stall = (r_state == ST_MEM_WAIT) && !mem_ready;

    // Saturating event counters
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_perf_lu  <= '0;
            r_perf_mem <= '0;
            r_perf_fl  <= '0;
        end else begin
            if (w_fire_lu && (r_perf_lu != PERF_MAX)) begin
                r_perf_lu <= r_perf_lu + 1'b1;
            end
            if (w_mem_stall && (r_perf_mem != PERF_MAX)) begin
                r_perf_mem <= r_perf_mem + 1'b1;
            end
            if (w_fire_br && (r_perf_fl != PERF_MAX)) begin
                r_perf_fl <= r_perf_fl + 1'b1;
            end
        end
    end

    assign perf_lu_stalls  = r_perf_lu;
    assign perf_mem_stalls = r_perf_mem;
    assign perf_flushes    = r_perf_fl;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a small watchdog limit.
// Expected control words are queued when each step is driven and compared mid-cycle.
module tb_hazard_stall_ctrl;

    localparam int REG_ADDR_W  = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 16;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}
    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_RST = 7'b0010101;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_JMP = 7'b1111010;
    localparam logic [6:0] C_TMO = 7'b1101011;

    logic clk = 1'b0;
    logic arst;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_mem_read, ex_branch_taken, id_jump, mem_req, mem_ready;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, mem_wb_flush, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;
`endif

    typedef struct {
        string      tag;
        logic [6:0] ctrl;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] obs;
    assign obs = {pc_write, if_id_write, if_id_flush, id_ex_write,
                  id_ex_flush, ex_mem_write, mem_wb_flush};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .REG_ADDR_W  (REG_ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .id_jump         (id_jump),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_flush    (mem_wb_flush),
`ifdef HAZARD_PERF_CNT_EN
        .perf_lu_stalls  (perf_lu_stalls),
        .perf_mem_stalls (perf_mem_stalls),
        .perf_flushes    (perf_flushes),
`endif
        .mem_timeout_err (mem_timeout_err)
    );

    // Drive one cycle of inputs, queue its expected outputs, compare mid-cycle
    task automatic step(input string tag, input logic a,
                        input logic mr, input logic [REG_ADDR_W-1:0] rd,
                        input logic [REG_ADDR_W-1:0] rs1, input logic [REG_ADDR_W-1:0] rs2,
                        input logic u2, input logic br, input logic jmp,
                        input logic req, input logic rdy,
                        input logic [6:0] e_ctrl, input logic e_err);
        exp_t e;
        exp_t g;
        arst            = a;
        ex_mem_read     = mr;
        ex_rd           = rd;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
        ex_branch_taken = br;
        id_jump         = jmp;
        mem_req         = req;
        mem_ready       = rdy;
        e.tag  = tag;
        e.ctrl = e_ctrl;
        e.err  = e_err;
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        checks++;
        assert (obs === g.ctrl) else begin
            errors++;
            $error("FAIL %s ctrl observed=%b expected=%b", g.tag, obs, g.ctrl);
        end
        checks++;
        assert (mem_timeout_err === g.err) else begin
            errors++;
            $error("FAIL %s err observed=%b expected=%b", g.tag, mem_timeout_err, g.err);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic check_perf(input string tag, input int e_lu, input int e_mem, input int e_fl);
        checks++;
        assert (perf_lu_stalls === CNT_W'(e_lu)) else begin
            errors++;
            $error("FAIL %s perf_lu observed=%0d expected=%0d", tag, perf_lu_stalls, e_lu);
        end
        checks++;
        assert (perf_mem_stalls === CNT_W'(e_mem)) else begin
            errors++;
            $error("FAIL %s perf_mem observed=%0d expected=%0d", tag, perf_mem_stalls, e_mem);
        end
        checks++;
        assert (perf_flushes === CNT_W'(e_fl)) else begin
            errors++;
            $error("FAIL %s perf_fl observed=%0d expected=%0d", tag, perf_flushes, e_fl);
        end
    endtask
`endif

    initial begin
        //    tag           arst mr rd  rs1 rs2 u2 br jmp req rdy  ctrl   err
        step("reset",       1,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_RST, 0);
        step("idle",        0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 0);
        step("lu_c0",       0,   1, 5,  5,  2,  0, 0, 0,  0,  0,   C_LU,  0);
        step("lu_c1_stall", 0,   1, 5,  5,  2,  0, 0, 0,  0,  0,   C_DEF, 0);
        step("lu_c2_run",   0,   1, 5,  5,  2,  0, 0, 0,  0,  0,   C_LU,  0);
        step("lu_done",     0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 0);
        step("rd_zero",     0,   1, 0,  0,  0,  1, 0, 0,  0,  0,   C_DEF, 0);
        step("rs2_unused",  0,   1, 7,  3,  7,  0, 0, 0,  0,  0,   C_DEF, 0);
        step("rs2_used",    0,   1, 7,  3,  7,  1, 0, 0,  0,  0,   C_LU,  0);
        step("rs2_stall",   0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 0);
        step("br_over_lu",  0,   1, 9,  9,  2,  0, 1, 0,  0,  0,   C_BR,  0);
        step("br_then_run", 0,   1, 9,  9,  2,  0, 0, 0,  0,  0,   C_LU,  0);
        step("br_lu_stall", 0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 0);
        step("jump",        0,   0, 3,  1,  2,  0, 0, 1,  0,  0,   C_JMP, 0);
        step("lu_over_jmp", 0,   1, 4,  4,  2,  0, 0, 1,  0,  0,   C_LU,  0);
        step("jmp_stall",   0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 0);
        step("mw_frz1",     0,   0, 3,  1,  2,  0, 1, 0,  1,  0,   C_FRZ, 0);
        step("mw_frz2",     0,   0, 3,  1,  2,  0, 1, 0,  1,  0,   C_FRZ, 0);
        step("mw_frz3",     0,   0, 3,  1,  2,  0, 1, 0,  1,  0,   C_FRZ, 0);
        step("mw_release",  0,   0, 3,  1,  2,  0, 1, 0,  1,  1,   C_BR,  0);
        step("mw_after",    0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 0);
        step("single_acc",  0,   0, 3,  1,  2,  0, 0, 0,  1,  1,   C_DEF, 0);
        step("ready_only",  0,   0, 3,  1,  2,  0, 0, 0,  0,  1,   C_DEF, 0);
        step("tmo_w1",      0,   0, 3,  1,  2,  0, 0, 0,  1,  0,   C_FRZ, 0);
        step("tmo_w2",      0,   0, 3,  1,  2,  0, 0, 0,  1,  0,   C_FRZ, 0);
        step("tmo_w3",      0,   0, 3,  1,  2,  0, 0, 0,  1,  0,   C_FRZ, 0);
        step("tmo_w4",      0,   0, 3,  1,  2,  0, 0, 0,  1,  0,   C_FRZ, 0);
        step("tmo_expire",  0,   0, 3,  1,  2,  0, 0, 0,  1,  0,   C_TMO, 0);
        step("tmo_run",     0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 1);
        step("tmo_sticky",  0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 1);
`ifdef HAZARD_PERF_CNT_EN
        check_perf("perf_pre_rst", 5, 6, 2);
`endif
        step("rst_mw_in",   0,   0, 3,  1,  2,  0, 0, 0,  1,  0,   C_FRZ, 1);
        step("rst_mw_wait", 0,   0, 3,  1,  2,  0, 0, 0,  1,  0,   C_FRZ, 1);
        step("rst_mid_mw",  1,   0, 3,  1,  2,  0, 0, 0,  1,  0,   C_RST, 0);
        step("rst_release", 0,   0, 3,  1,  2,  0, 0, 0,  0,  0,   C_DEF, 0);
`ifdef HAZARD_PERF_CNT_EN
        check_perf("perf_post_rst", 0, 0, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
